laser_reward_ctrl: RTL and testbench
====================================

Name: laser_reward_ctrl

Overview:
- Sequences the laser power-up: grants a limited number of laser shots when the tank picks up the reward.
- Each fire request runs a charge → beam → cooldown cycle; an unused grant expires after a hold timeout.
- Drives the laser beam renderer (reward_laser strobe plus position/direction latched at fire time) and a shots-left counter for the HUD.
- Sits between the tank input/pickup logic and the laser renderer and hit detection.

Parameters:
- SHOTS, 3, shots granted per pickup (1..7)
- CHARGE_TICKS, 8, game ticks spent charging before the beam appears (≥1)
- FIRE_TICKS, 30, game ticks the beam stays on (≥1)
- COOL_TICKS, 20, game ticks of lockout after the beam (≥1)
- HOLD_TICKS, 600, game ticks an armed, unused grant survives (≥1)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- enable_reward  in  1  game running; low aborts to IDLE
- tick  in  1  one-cycle game-time pulse (frame rate); all timers count tick pulses
- reward_pickup  in  1  one-cycle pulse: tank collected the laser reward
- fire_req  in  1  one-cycle pulse: player fire request
- mytank_xpos  in  5  tank grid column
- mytank_ypos  in  5  tank grid row
- mytank_dir  in  2  tank direction (00 up, 01 down, 10 left, 11 right)
- reward_laser  out  1  beam active; renderer and hit detection qualify on this
- laser_xpos  out  5  column latched at fire
- laser_ypos  out  5  row latched at fire
- laser_dir  out  2  direction latched at fire
- charging  out  1  high during CHARGE
- shots_left  out  3  remaining shots
- laser_ready  out  1  high in ARMED with shots_left>0

Behaviour:
- Reset values: all outputs 0; state IDLE; timer 0.
- All outputs are registered and change one clk after the causing event.
- Timer: 10-bit, loaded with the state's parameter on state entry, decremented on tick. The state ends on the tick where timer==1; the next state is entered on the following clk.
- IDLE:
  - reward_pickup → ARMED; shots_left=SHOTS; timer=HOLD_TICKS.
- ARMED:
  - fire_req → CHARGE; latch laser_xpos/ypos/dir from the tank inputs that same cycle; shots_left decrements; timer=CHARGE_TICKS.
  - Hold timer expiry → IDLE; shots_left=0.
  - fire_req and the expiring tick in the same cycle: fire wins.
- CHARGE:
  - charging=1; fire_req ignored.
  - Expiry → FIRE; timer=FIRE_TICKS.
- FIRE:
  - reward_laser=1; latched position/direction held constant even if the tank moves or turns.
  - Expiry → COOL; timer=COOL_TICKS.
- COOL:
  - fire_req ignored (not queued).
  - Expiry → ARMED with timer=HOLD_TICKS if shots_left>0, else IDLE.
- reward_pickup outside IDLE is ignored, unless LASER_REFILL_EN is defined.
- enable_reward low, in any state and regardless of other inputs: next clk IDLE, all outputs 0, shots cleared. While it stays low, pickups and fires are ignored.
- rst mid-beam: reward_laser drops on the next clk; no partial state survives.
- laser_ready = (state==ARMED) && (shots_left!=0).
- No tick pulses → the FSM waits indefinitely in timed states.

Optional Feature:
- Macro: LASER_REFILL_EN.
- Defined: reward_pickup in ARMED/CHARGE/FIRE/COOL adds SHOTS to shots_left, saturating at 7. In ARMED the hold timer also reloads to HOLD_TICKS. The current state is otherwise unaffected.
- Undefined: pickups outside IDLE are ignored.

Decomposition:
- Package laser_pkg holds:
  - state encoding constants (IDLE=0, ARMED=1, CHARGE=2, FIRE=3, COOL=4)
  - direction codes DIR_UP/DOWN/LEFT/RIGHT
  - SHOTS_MAX=7
- One sub-module, tick_timer: loadable 10-bit down-counter with tick enable and a done pulse. It is reused by the FSM for all timed states.

Test Plan:
- Basic shot: reset; pickup; fire at xpos=3,ypos=4,dir=01. Required: charging=1 for 8 ticks, then reward_laser=1 for exactly 30 ticks with laser_xpos=3, laser_ypos=4, laser_dir=01; shots_left 3→2; laser_ready returns after 20 cool ticks.
- Exhaust: pickup, three full fire cycles. Required: after the third COOL, state IDLE, shots_left=0, laser_ready=0; a fourth fire_req gives no beam.
- Expiry: pickup, no fire for 600 ticks. Required: IDLE with shots_left=0. A fire_req and the 600th tick in the same cycle: CHARGE entered, shots_left=2.
- Movement during beam: change mytank_dir/xpos during FIRE. Required: laser_* outputs unchanged. fire_req during CHARGE/COOL is ignored; shots_left unchanged.
- Abort: deassert enable_reward mid-FIRE, and separately assert rst mid-FIRE. Required: reward_laser=0 and shots_left=0 one clk later; state IDLE.
- Refill (LASER_REFILL_EN): pickup twice while ARMED and once in FIRE with shots_left=2. Required: 2→5→7 (saturated) under the macro; unchanged without it.

Source files
------------

// File: rtl/laser_pkg.sv
// Shared encodings for the laser reward controller: FSM states, tank direction codes, shot limits.
// Used by laser_reward_ctrl (optional LASER_REFILL_EN refill) and tick_timer.
package laser_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ARMED  = 3'd1,
        CHARGE = 3'd2,
        FIRE   = 3'd3,
        COOL   = 3'd4
    } laser_state_e;

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_DOWN  = 2'b01;
    localparam logic [1:0] DIR_LEFT  = 2'b10;
    localparam logic [1:0] DIR_RIGHT = 2'b11;

    localparam int unsigned SHOTS_MAX = 7;
    localparam int unsigned TIMER_W   = 10;

    // Adds to the shot count without wrapping past what the 3-bit HUD counter can show.
    function automatic logic [2:0] shots_sat_add(input logic [2:0] a, input logic [2:0] b);
        logic [3:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return (sum > 4'(SHOTS_MAX)) ? 3'(SHOTS_MAX) : sum[2:0];
    endfunction

endpackage

// File: rtl/laser_reward_ctrl_tick_timer.sv
// tick_timer: loadable 10-bit down-counter stepped by the game tick.
// done pulses on the tick that takes the count from 1 to 0; a load overrides that tick.
module tick_timer
    import laser_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [TIMER_W-1:0] load_val,
    input  logic               tick,
    output logic               done
);

    logic [TIMER_W-1:0] count_d;
    logic [TIMER_W-1:0] count_q;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (tick && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done = tick && (count_q == TIMER_W'(1));

endmodule

// File: rtl/laser_reward_ctrl.sv
// Laser power-up sequencer: grants shots on pickup and runs charge -> beam -> cooldown per fire.
// Define LASER_REFILL_EN to let pickups outside IDLE top up the shot count.
module laser_reward_ctrl
    import laser_pkg::*;
#(
    parameter int unsigned SHOTS        = 3,
    parameter int unsigned CHARGE_TICKS = 8,
    parameter int unsigned FIRE_TICKS   = 30,
    parameter int unsigned COOL_TICKS   = 20,
    parameter int unsigned HOLD_TICKS   = 600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable_reward,
    input  logic       tick,
    input  logic       reward_pickup,
    input  logic       fire_req,
    input  logic [4:0] mytank_xpos,
    input  logic [4:0] mytank_ypos,
    input  logic [1:0] mytank_dir,
    output logic       reward_laser,
    output logic [4:0] laser_xpos,
    output logic [4:0] laser_ypos,
    output logic [1:0] laser_dir,
    output logic       charging,
    output logic [2:0] shots_left,
    output logic       laser_ready
);

    laser_state_e       state_q, state_d;
    logic [2:0]         shots_q, shots_d, shots_base;
    logic [4:0]         xpos_q, xpos_d, ypos_q, ypos_d;
    logic [1:0]         dir_q, dir_d;
    logic               reward_laser_q, reward_laser_d;
    logic               charging_q, charging_d;
    logic               ready_q, ready_d;
    logic               refill;
    logic               timer_load, timer_done;
    logic [TIMER_W-1:0] timer_load_val;

    tick_timer u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (timer_load),
        .load_val (timer_load_val),
        .tick     (tick),
        .done     (timer_done)
    );

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_d    = state_q;
        xpos_d     = xpos_q;
        ypos_d     = ypos_q;
        dir_d      = dir_q;
`ifdef LASER_REFILL_EN
        refill     = reward_pickup && (state_q != IDLE);
`else
        refill     = 1'b0;
`endif
        // A refill lands before any fire or cooldown decision made in the same cycle.
        shots_base = refill ? shots_sat_add(shots_q, 3'(SHOTS)) : shots_q;
        shots_d    = shots_base;

        unique case (state_q)
            IDLE: begin
                if (reward_pickup) begin
                    state_d = ARMED;
                    shots_d = 3'(SHOTS);
                end
            end
            ARMED: begin
                if (fire_req && (shots_base != '0)) begin
                    state_d = CHARGE;
                    shots_d = shots_base - 3'd1;
                    xpos_d  = mytank_xpos;
                    ypos_d  = mytank_ypos;
                    dir_d   = mytank_dir;
                end else if (!refill && timer_done) begin
                    state_d = IDLE;
                    shots_d = '0;
                end
            end
            CHARGE: if (timer_done) state_d = FIRE;
            FIRE:   if (timer_done) state_d = COOL;
            COOL:   if (timer_done) state_d = (shots_base != '0) ? ARMED : IDLE;
            default: state_d = IDLE;
        endcase

        if (!enable_reward) begin
            state_d = IDLE;
            shots_d = '0;
            xpos_d  = '0;
            ypos_d  = '0;
            dir_d   = DIR_UP;
        end

        timer_load = (state_d != state_q) || (refill && (state_q == ARMED) && (state_d == ARMED));
        unique case (state_d)
            ARMED:   timer_load_val = TIMER_W'(HOLD_TICKS);
            CHARGE:  timer_load_val = TIMER_W'(CHARGE_TICKS);
            FIRE:    timer_load_val = TIMER_W'(FIRE_TICKS);
            COOL:    timer_load_val = TIMER_W'(COOL_TICKS);
            default: timer_load_val = '0;
        endcase

        reward_laser_d = (state_d == FIRE);
        charging_d     = (state_d == CHARGE);
        ready_d        = (state_d == ARMED) && (shots_d != '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            shots_q        <= '0;
            xpos_q         <= '0;
            ypos_q         <= '0;
            dir_q          <= DIR_UP;
            reward_laser_q <= 1'b0;
            charging_q     <= 1'b0;
            ready_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            shots_q        <= shots_d;
            xpos_q         <= xpos_d;
            ypos_q         <= ypos_d;
            dir_q          <= dir_d;
            reward_laser_q <= reward_laser_d;
            charging_q     <= charging_d;
            ready_q        <= ready_d;
        end
    end

    assign reward_laser = reward_laser_q;
    assign laser_xpos   = xpos_q;
    assign laser_ypos   = ypos_q;
    assign laser_dir    = dir_q;
    assign charging     = charging_q;
    assign shots_left   = shots_q;
    assign laser_ready  = ready_q;

endmodule

// File: tb/tb_laser_reward_ctrl.sv
// Self-checking bench for laser_reward_ctrl: directed scenarios plus random traffic,
// all compared against a phase/elapsed-tick model; refill expectations follow LASER_REFILL_EN.
module tb_laser_reward_ctrl;
    import laser_pkg::*;

    localparam int SHOTS = 3;
    localparam int CHG   = 8;
    localparam int BEAM  = 30;
    localparam int COOL  = 20;
    localparam int HOLD  = 600;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable_reward;
    logic       tick;
    logic       reward_pickup;
    logic       fire_req;
    logic [4:0] mytank_xpos;
    logic [4:0] mytank_ypos;
    logic [1:0] mytank_dir;
    logic       reward_laser;
    logic [4:0] laser_xpos;
    logic [4:0] laser_ypos;
    logic [1:0] laser_dir;
    logic       charging;
    logic [2:0] shots_left;
    logic       laser_ready;

    always #5 clk = ~clk;

    laser_reward_ctrl #(
        .SHOTS(SHOTS), .CHARGE_TICKS(CHG), .FIRE_TICKS(BEAM), .COOL_TICKS(COOL), .HOLD_TICKS(HOLD)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .enable_reward (enable_reward),
        .tick          (tick),
        .reward_pickup (reward_pickup),
        .fire_req      (fire_req),
        .mytank_xpos   (mytank_xpos),
        .mytank_ypos   (mytank_ypos),
        .mytank_dir    (mytank_dir),
        .reward_laser  (reward_laser),
        .laser_xpos    (laser_xpos),
        .laser_ypos    (laser_ypos),
        .laser_dir     (laser_dir),
        .charging      (charging),
        .shots_left    (shots_left),
        .laser_ready   (laser_ready)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Reference model: which phase the game is in and how many ticks it has lasted.
    typedef enum {P_OFF, P_WAIT, P_CHG, P_BEAM, P_LOCK} phase_e;
    phase_e m_phase;
    int     m_elapsed;
    int     m_shots;
    int     m_x, m_y, m_d;

    function automatic int dur(input phase_e p);
        case (p)
            P_WAIT:  return HOLD;
            P_CHG:   return CHG;
            P_BEAM:  return BEAM;
            P_LOCK:  return COOL;
            default: return 0;
        endcase
    endfunction

    task automatic model_step();
        bit expire;
        bit refill;
        if (rst || !enable_reward) begin
            m_phase = P_OFF; m_elapsed = 0; m_shots = 0; m_x = 0; m_y = 0; m_d = 0;
            return;
        end
        refill = 0;
`ifdef LASER_REFILL_EN
        refill = reward_pickup && (m_phase != P_OFF);
`endif
        if (refill) m_shots = (m_shots + SHOTS > 7) ? 7 : m_shots + SHOTS;
        expire = 0;
        if (tick && m_phase != P_OFF) begin
            m_elapsed++;
            expire = (m_elapsed >= dur(m_phase));
        end
        case (m_phase)
            P_OFF: if (reward_pickup) begin
                m_phase = P_WAIT; m_elapsed = 0; m_shots = SHOTS;
            end
            P_WAIT: begin
                if (fire_req && m_shots > 0) begin
                    m_x = mytank_xpos; m_y = mytank_ypos; m_d = mytank_dir;
                    m_shots--; m_phase = P_CHG; m_elapsed = 0;
                end else if (refill) begin
                    m_elapsed = 0;
                end else if (expire) begin
                    m_phase = P_OFF; m_shots = 0; m_elapsed = 0;
                end
            end
            P_CHG:  if (expire) begin m_phase = P_BEAM; m_elapsed = 0; end
            P_BEAM: if (expire) begin m_phase = P_LOCK; m_elapsed = 0; end
            P_LOCK: if (expire) begin m_phase = (m_shots > 0) ? P_WAIT : P_OFF; m_elapsed = 0; end
            default: m_phase = P_OFF;
        endcase
    endtask

    task automatic compare_all();
        check("reward_laser", reward_laser, m_phase == P_BEAM);
        check("charging",     charging,     m_phase == P_CHG);
        check("laser_ready",  laser_ready,  (m_phase == P_WAIT) && (m_shots > 0));
        check("shots_left",   shots_left,   m_shots);
        check("laser_xpos",   laser_xpos,   m_x);
        check("laser_ypos",   laser_ypos,   m_y);
        check("laser_dir",    laser_dir,    m_d);
    endtask

    task automatic step(input logic t, input logic pk, input logic fr);
        tick = t; reward_pickup = pk; fire_req = fr;
        @(posedge clk);
        model_step();
        #1;
        compare_all();
        tick = 1'b0; reward_pickup = 1'b0; fire_req = 1'b0;
    endtask

    task automatic run_ticks(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit any_beam;
        rst = 1'b1; enable_reward = 1'b1; tick = 1'b0; reward_pickup = 1'b0; fire_req = 1'b0;
        mytank_xpos = '0; mytank_ypos = '0; mytank_dir = DIR_UP;

        // Reset state
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        rst = 1'b0;
        check("reset_shots", shots_left, 0);
        check("reset_beam",  reward_laser, 0);

        // Basic shot: charge 8, beam 30 with latched position, cool 20
        step(1'b1, 1'b1, 1'b0);
        check("pickup_shots", shots_left, 3);
        mytank_xpos = 5'd3; mytank_ypos = 5'd4; mytank_dir = DIR_DOWN;
        step(1'b0, 1'b0, 1'b1);
        check("fire_shots", shots_left, 2);
        n = 0;
        for (int i = 0; i < 100 && charging; i++) begin
            n++;
            step(1'b1, 1'b0, i == 3);
        end
        check("charge_ticks", n, CHG);
        check("charge_fire_ignored", shots_left, 2);
        check("beam_x", laser_xpos, 3);
        check("beam_y", laser_ypos, 4);
        check("beam_dir", laser_dir, DIR_DOWN);
        n = 0;
        for (int i = 0; i < 100 && reward_laser; i++) begin
            n++;
            mytank_xpos = 5'($urandom); mytank_ypos = 5'($urandom); mytank_dir = 2'($urandom);
            step(1'b1, 1'b0, 1'b0);
        end
        check("beam_ticks", n, BEAM);
        check("beam_hold_x", laser_xpos, 3);
        check("beam_hold_dir", laser_dir, DIR_DOWN);
        n = 0;
        for (int i = 0; i < 100 && !laser_ready && !charging && !reward_laser; i++) begin
            n++;
            step(1'b1, 1'b0, i == 5);
        end
        check("cool_ticks", n, COOL);
        check("cool_fire_ignored", shots_left, 2);

        // Exhaust: two more full cycles, then a fourth fire gives nothing
        for (int s = 0; s < 2; s++) begin
            step(1'b0, 1'b0, 1'b1);
            run_ticks(CHG + BEAM + COOL);
        end
        check("exhaust_shots", shots_left, 0);
        check("exhaust_ready", laser_ready, 0);
        any_beam = 0;
        step(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 50; i++) begin
            any_beam |= reward_laser | charging;
            step(1'b1, 1'b0, 1'b0);
        end
        check("fourth_fire_no_beam", any_beam, 0);

        // Hold expiry, then fire colliding with the expiring tick
        step(1'b0, 1'b1, 1'b0);
        run_ticks(HOLD);
        check("expiry_shots", shots_left, 0);
        check("expiry_ready", laser_ready, 0);
        step(1'b0, 1'b1, 1'b0);
        run_ticks(HOLD - 1);
        step(1'b1, 1'b0, 1'b1);
        check("fire_wins_charging", charging, 1);
        check("fire_wins_shots", shots_left, 2);

        // Abort mid-beam with enable_reward
        run_ticks(CHG + 10);
        check("abort_pre_beam", reward_laser, 1);
        enable_reward = 1'b0;
        step(1'b0, 1'b0, 1'b0);
        check("abort_beam", reward_laser, 0);
        check("abort_shots", shots_left, 0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        check("abort_pickup_ignored", shots_left, 0);
        enable_reward = 1'b1;

        // Reset mid-beam
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        run_ticks(CHG + 5);
        check("rst_pre_beam", reward_laser, 1);
        rst = 1'b1;
        step(1'b1, 1'b1, 1'b1);
        rst = 1'b0;
        check("rst_beam", reward_laser, 0);
        check("rst_shots", shots_left, 0);
        check("rst_xpos", laser_xpos, 0);

        // Refill: ARMED with 2 shots, pickup twice, fire, pickup during beam
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        run_ticks(CHG + BEAM + COOL);
        check("refill_start", shots_left, 2);
        step(1'b0, 1'b1, 1'b0);
`ifdef LASER_REFILL_EN
        check("refill_first", shots_left, 5);
`else
        check("refill_first", shots_left, 2);
`endif
        step(1'b0, 1'b1, 1'b0);
`ifdef LASER_REFILL_EN
        check("refill_saturate", shots_left, 7);
`else
        check("refill_saturate", shots_left, 2);
`endif
        step(1'b0, 1'b0, 1'b1);
        run_ticks(CHG + 3);
        step(1'b0, 1'b1, 1'b0);
`ifdef LASER_REFILL_EN
        check("refill_in_beam", shots_left, 7);
`else
        check("refill_in_beam", shots_left, 1);
`endif
        check("refill_beam_on", reward_laser, 1);

        // Random traffic against the model
        for (int i = 0; i < 5000; i++) begin
            rst           = ($urandom_range(0, 599) == 0);
            enable_reward = ($urandom_range(0, 249) != 0);
            mytank_xpos   = 5'($urandom);
            mytank_ypos   = 5'($urandom);
            mytank_dir    = 2'($urandom);
            step(1'($urandom), $urandom_range(0, 39) == 0, $urandom_range(0, 9) == 0);
        end
        rst = 1'b0;
        enable_reward = 1'b1;
        step(1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
